// File: rtl/dct_butterfly_sequencer_if.sv
// rtl/dct_butterfly_sequencer_if.sv - row, butterfly-operand and completion signals of the DCT butterfly sequencer
interface dct_butterfly_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic        [8*WIDTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   op_x;
  logic signed [WIDTH-1:0]   op_y;
  logic                      op_valid;
  logic        [1:0]         sele;
  logic        [3:0]         cap_en;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic        [CNT_W-1:0]   row_cnt;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, op_x, op_y, op_valid, sele, cap_en, out_valid, busy, row_cnt
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, op_x, op_y, op_valid, sele, cap_en, out_valid, busy, row_cnt
  );
endinterface

// File: rtl/dct_butterfly_sequencer.sv
// rtl/dct_butterfly_sequencer.sv - issues the four symmetric pairs of one 8-sample row to a shared butterfly
module dct_butterfly_sequencer #(
  parameter int WIDTH  = 8,
  parameter int BF_LAT = 1,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  dct_butterfly_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int LINE_W = (BF_LAT > 0) ? BF_LAT : 1;

  state_t              state;
  logic [8*WIDTH-1:0]  row;
  logic [1:0]          i;
  logic [1:0]          c;
  logic [LINE_W-1:0]   vdly;
  logic                accept;
  logic                opv_next;
  logic                cap_fire;
  logic [1:0]          cidx;

  function automatic logic [WIDTH-1:0] sample(input logic [8*WIDTH-1:0] r, input logic [2:0] k);
    return r[WIDTH*k +: WIDTH];
  endfunction

  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign opv_next     = accept || ((state == ISSUE) && (i != 2'd3));
  // vdly[j] mirrors op_valid j cycles back, so the tap feeding the registered strobe is BF_LAT-1
  assign cap_fire     = (BF_LAT == 0) ? opv_next : vdly[LINE_W-1];
  assign cidx         = accept ? 2'd0 : c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      i             <= 2'd0;
      c             <= 2'd0;
      vdly          <= '0;
      bus.op_x      <= '0;
      bus.op_y      <= '0;
      bus.op_valid  <= 1'b0;
      bus.sele      <= 2'd0;
      bus.cap_en    <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.row_cnt   <= '0;
    end else begin
      vdly[0] <= opv_next;
      for (int j = 1; j < LINE_W; j++) begin
        vdly[j] <= vdly[j-1];
      end

      if (cap_fire) begin
        bus.cap_en <= 4'b0001 << cidx;
        bus.sele   <= cidx;
        c          <= cidx + 2'd1;
      end else begin
        bus.cap_en <= 4'd0;
        c          <= cidx;
      end

      case (state)
        IDLE: ;
        ISSUE: begin
          if (i == 2'd3) begin
            bus.op_valid <= 1'b0;
            if (BF_LAT > 0) begin
              state <= DRAIN;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
            end
          end else begin
            i        <= i + 2'd1;
            bus.op_x <= sample(row, {1'b0, i + 2'd1});
            bus.op_y <= sample(row, 3'd6 - {1'b0, i});
          end
        end
        DRAIN: begin
          if (bus.cap_en[3]) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.row_cnt   <= bus.row_cnt + 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // a new row overrides the IDLE fall-through of DONE, giving back-to-back rows with no bubble
      if (accept) begin
        row          <= bus.in_data;
        bus.op_x     <= sample(bus.in_data, 3'd0);
        bus.op_y     <= sample(bus.in_data, 3'd7);
        bus.op_valid <= 1'b1;
        bus.busy     <= 1'b1;
        i            <= 2'd0;
        state        <= ISSUE;
      end
    end
  end
endmodule
